// File: rtl/trng_harvest_ctrl_if.sv
// trng_harvest_ctrl_if: control and data handshake between the harvest sequencer and the dual_trng core
// master (sequencer): drives trng_rst/trng_calib/trng_en/trng_read, receives trng_ready/trng_random
// slave (core side): the mirror image
interface trng_harvest_ctrl_if;
  logic        trng_rst;
  logic        trng_calib;
  logic        trng_en;
  logic        trng_read;
  logic        trng_ready;
  logic [31:0] trng_random;
  modport master (output trng_rst, trng_calib, trng_en, trng_read, input trng_ready, trng_random);
  modport slave (input trng_rst, trng_calib, trng_en, trng_read, output trng_ready, trng_random);
endinterface

// File: rtl/trng_harvest_ctrl.sv
// trng_harvest_ctrl: sequences dual_trng through reset/calibration/run and buffers returned words in a FIFO
// Ports: clk, rst_n (async active-low); start/stop/clr_err control pulses; calib_cycles, threshold config;
//   pop/rnd_data/rnd_valid/level FIFO read side; busy/state/irq/err_timeout/err_health status;
//   trng (master modport) towards the entropy core.
// Optional feature: define TRNG_HEALTH_EN to add a repetition-count health test driving err_health.
module trng_harvest_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       clr_err,
  input  logic [31:0]                calib_cycles,
  input  logic [3:0]                 threshold,
  input  logic                       pop,
  output logic [31:0]                rnd_data,
  output logic                       rnd_valid,
  output logic [3:0]                 level,
  output logic                       busy,
  output logic [2:0]                 state,
  output logic                       irq,
  output logic                       err_timeout,
  output logic                       err_health,
  trng_harvest_ctrl_if.master        trng
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_CALIB = 3'd2,
    S_RUN   = 3'd3,
    S_WAIT  = 3'd4
  } state_t;
  state_t cur, nxt;
  logic [31:0]   cal_cnt;
  logic          rst_cnt;
  logic [TW-1:0] to_cnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          capture, push, do_pop, timeout, health_fail;
  // A word returned in the same cycle as stop is discarded
  assign capture = cur == S_WAIT && trng.trng_ready && !stop;
  assign timeout = cur == S_WAIT && !trng.trng_ready && !stop && to_cnt == TW'(TIMEOUT - 1);
  assign push    = capture && !health_fail;
  assign do_pop  = pop && level != 4'd0;
`ifdef TRNG_HEALTH_EN
  logic [31:0] prev_word;
  logic [1:0]  rep_cnt;
  logic        same;
  // rep_cnt is the length of the current run of identical words; 0 means no word seen since RST
  assign same        = rep_cnt != 2'd0 && trng.trng_random == prev_word;
  assign health_fail = capture && same && rep_cnt == 2'd2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_word  <= '0;
      rep_cnt    <= '0;
      err_health <= 1'b0;
    end else begin
      if (cur == S_IDLE && nxt == S_RST) begin
        prev_word <= '0;
        rep_cnt   <= '0;
      end else if (capture) begin
        prev_word <= trng.trng_random;
        rep_cnt   <= same ? rep_cnt + 2'd1 : 2'd1;
      end
      err_health <= health_fail | (err_health & ~clr_err);
    end
`else
  assign health_fail = 1'b0;
  assign err_health  = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= S_IDLE;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    if (stop) nxt = S_IDLE;
    else
      case (cur)
        S_IDLE:  nxt = start ? S_RST : S_IDLE;
        S_RST:   nxt = !rst_cnt ? S_RST : cal_cnt == 32'd0 ? S_RUN : S_CALIB;
        S_CALIB: nxt = cal_cnt == 32'd1 ? S_RUN : S_CALIB;
        S_RUN:   nxt = level < 4'(DEPTH) ? S_WAIT : S_RUN;
        S_WAIT:  nxt = health_fail || timeout ? S_IDLE : trng.trng_ready ? S_RUN : S_WAIT;
        default: nxt = S_IDLE;
      endcase
  end
  always_comb begin
    trng.trng_rst   = cur == S_RST;
    trng.trng_calib = cur == S_CALIB;
    trng.trng_en    = cur == S_CALIB || cur == S_RUN || cur == S_WAIT;
    trng.trng_read  = cur == S_WAIT;
    busy            = cur != S_IDLE;
    state           = cur;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cal_cnt     <= '0;
      rst_cnt     <= 1'b0;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
      irq         <= 1'b0;
    end else begin
      cal_cnt     <= cur == S_IDLE && start ? calib_cycles : cur == S_CALIB ? cal_cnt - 32'd1 : cal_cnt;
      rst_cnt     <= cur == S_RST ? ~rst_cnt : 1'b0;
      to_cnt      <= cur == S_WAIT ? to_cnt + TW'(1) : '0;
      err_timeout <= timeout | (err_timeout & ~clr_err);
      irq         <= threshold != 4'd0 && level >= threshold;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= trng.trng_random;
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level  <= level + 4'(push) - 4'(do_pop);
    end
  assign rnd_valid = level != 4'd0;
  assign rnd_data  = rnd_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_trng_harvest_ctrl.sv
// tb_trng_harvest_ctrl: directed self-checking bench for trng_harvest_ctrl with a simple dual_trng responder
module tb_trng_harvest_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, clr_err, pop;
  logic [31:0] calib_cycles;
  logic [3:0]  threshold;
  logic [31:0] rnd_data;
  logic        rnd_valid, busy, irq, err_timeout, err_health;
  logic [3:0]  level;
  logic [2:0]  state;
  logic        resp_en, rep_mode, man_ready, model_ready;
  logic [31:0] man_random, model_random, n_sent;
  int          rd_age;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_wait;
  logic        ok;
  trng_harvest_ctrl_if bus ();
  assign bus.trng_ready  = resp_en ? model_ready : man_ready;
  assign bus.trng_random = resp_en ? model_random : man_random;
  trng_harvest_ctrl #(.DEPTH(4), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr_err(clr_err),
    .calib_cycles(calib_cycles), .threshold(threshold), .pop(pop),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .level(level), .busy(busy),
    .state(state), .irq(irq), .err_timeout(err_timeout), .err_health(err_health),
    .trng(bus)
  );
  always #5 clk = ~clk;
  // Core model: answers a read request on its 3rd cycle with an incrementing word (or a constant one)
  initial begin
    model_ready = 1'b0;
    model_random = '0;
    rd_age = 0;
    n_sent = '0;
    forever begin
      @(negedge clk);
      model_ready = 1'b0;
      rd_age = bus.trng_read ? rd_age + 1 : 0;
      if (resp_en && rd_age == 3) begin
        model_ready = 1'b1;
        model_random = rep_mode ? 32'hDEAD_BEEF : 32'hA000_0000 + n_sent;
        n_sent = n_sent + 32'd1;
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clr_err = 1'b0; pop = 1'b0;
    calib_cycles = '0; threshold = '0;
    resp_en = 1'b1; rep_mode = 1'b0; man_ready = 1'b0; man_random = '0;
    tick(2);
    chk("rst_status", 32'({state, level, busy, irq, err_timeout, err_health, rnd_valid}), 0);
    chk("rst_trng", 32'({bus.trng_rst, bus.trng_calib, bus.trng_en, bus.trng_read}), 0);
    chk("rst_data", rnd_data, 0);
    rst_n = 1'b1;
    tick();
    // Sequence with N=5: RST 2 cycles, CALIB 5 cycles, RUN, then WAIT with read
    start = 1'b1; calib_cycles = 32'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_phase", 32'({state, bus.trng_rst, bus.trng_calib}), 32'({3'd1, 1'b1, 1'b0}));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk("calib_phase", 32'({state, bus.trng_rst, bus.trng_calib, bus.trng_en}), 32'({3'd2, 1'b0, 1'b1, 1'b1}));
      tick();
    end
    chk("run_first", 32'({state, bus.trng_calib, bus.trng_read, bus.trng_en}), 32'({3'd3, 1'b0, 1'b0, 1'b1}));
    tick();
    chk("wait_first", 32'({state, bus.trng_read}), 32'({3'd4, 1'b1}));
    tick(3);
    chk("first_word", rnd_data, 32'hA000_0000);
    chk("first_level", 32'({level, rnd_valid, bus.trng_read, state}), 32'({4'd1, 1'b1, 1'b0, 3'd3}));
    // Fill without pops: level saturates and no further requests
    tick(20);
    chk("full_level", 32'({level, state, irq}), 32'({4'd4, 3'd3, 1'b0}));
    chk("full_head", rnd_data, 32'hA000_0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_no_read", 32'(bus.trng_read), 0);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pop_head", rnd_data, 32'hA000_0001);
    chk("pop_level", 32'(level), 3);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = level == 4'd4;
    end
    chk("refill", 32'(ok), 1);
    resp_en = 1'b0;
    threshold = 4'd2;
    tick();
    chk("irq_full", 32'({irq, state}), 32'({1'b1, 3'd3}));
    // Drain three words in order; irq follows level with one cycle lag
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("drain1", rnd_data, 32'hA000_0002);
    chk("drain1_st", 32'({level, state}), 32'({4'd3, 3'd3}));
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("drain2", rnd_data, 32'hA000_0003);
    chk("drain2_st", 32'({level, irq, state}), 32'({4'd2, 1'b1, 3'd4}));
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("drain3", rnd_data, 32'hA000_0004);
    chk("drain3_irq", 32'({level, irq}), 32'({4'd1, 1'b1}));
    tick();
    chk("irq_fall", 32'({level, irq}), 32'({4'd1, 1'b0}));
    // Core never answers: WAIT lasts exactly TIMEOUT cycles
    n_wait = 3;
    for (int i = 0; i < 1100 && state == 3'd4; i++) begin
      tick();
      if (state == 3'd4) n_wait++;
    end
    chk("timeout_len", n_wait, 1024);
    chk("timeout_st", 32'({err_timeout, state, busy}), 32'({1'b1, 3'd0, 1'b0}));
    chk("timeout_trng", 32'({bus.trng_rst, bus.trng_calib, bus.trng_en, bus.trng_read}), 0);
    chk("fifo_kept", rnd_data, 32'hA000_0004);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err", 32'(err_timeout), 0);
    pop = 1'b1;
    tick();
    chk("empty", 32'({level, rnd_valid}), 0);
    chk("empty_data", rnd_data, 0);
    tick();
    pop = 1'b0;
    chk("pop_empty", 32'({level, rnd_valid}), 0);
    // N=0: RST 2 cycles then RUN, read 3 cycles after start
    resp_en = 1'b1;
    start = 1'b1; calib_cycles = 32'd0;
    tick();
    start = 1'b0;
    chk("n0_rst1", 32'(state), 1);
    tick();
    chk("n0_rst2", 32'({state, bus.trng_rst}), 32'({3'd1, 1'b1}));
    tick();
    chk("n0_run", 32'({state, bus.trng_read, bus.trng_calib}), 32'({3'd3, 1'b0, 1'b0}));
    tick();
    chk("n0_read", 32'(bus.trng_read), 1);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      ok = level == 4'd2;
    end
    chk("lvl2_reached", 32'(ok), 1);
    resp_en = 1'b0;
    chk("irq_lag", 32'(irq), 0);
    tick();
    chk("irq_rise", 32'({irq, state}), 32'({1'b1, 3'd4}));
    // stop coincident with ready: word discarded
    man_ready = 1'b1; man_random = 32'h5555_AAAA; stop = 1'b1;
    tick();
    man_ready = 1'b0; stop = 1'b0;
    chk("stop_wait", 32'({state, level, busy}), 32'({3'd0, 4'd2, 1'b0}));
    chk("stop_trng", 32'({bus.trng_rst, bus.trng_calib, bus.trng_en, bus.trng_read}), 0);
    chk("stop_head", rnd_data, 32'hA000_0005);
    // Push and pop in the same cycle at level 2
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    chk("pp_wait", 32'(state), 4);
    man_ready = 1'b1; man_random = 32'h1234_5678; pop = 1'b1;
    tick();
    man_ready = 1'b0; pop = 1'b0;
    chk("pp_level", 32'({level, state}), 32'({4'd2, 3'd3}));
    chk("pp_head", rnd_data, 32'hA000_0006);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pp_tail", rnd_data, 32'h1234_5678);
    chk("pp_tail_lvl", 32'({level, state}), 32'({4'd1, 3'd0}));
    // stop during CALIB; start outside IDLE ignored
    start = 1'b1; calib_cycles = 32'd10;
    tick();
    start = 1'b0;
    tick(2);
    chk("cal_in", 32'({state, bus.trng_calib}), 32'({3'd2, 1'b1}));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored", 32'(state), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_calib", 32'({state, bus.trng_rst, bus.trng_calib, bus.trng_en, bus.trng_read}), 0);
    chk("stop_calib_lvl", 32'(level), 1);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    // Repeated identical words
    rep_mode = 1'b1; resp_en = 1'b1; calib_cycles = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef TRNG_HEALTH_EN
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      ok = state == 3'd0;
    end
    chk("health_idle", 32'(ok), 1);
    chk("health_st", 32'({level, err_health}), 32'({4'd2, 1'b1}));
    chk("health_word", rnd_data, 32'hDEAD_BEEF);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("health_clr", 32'(err_health), 0);
`else
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      ok = level == 4'd3;
    end
    chk("rep_all_pushed", 32'(ok), 1);
    chk("rep_st", 32'({err_health, busy}), 32'({1'b0, 1'b1}));
    chk("rep_word", rnd_data, 32'hDEAD_BEEF);
    stop = 1'b1;
    tick();
    stop = 1'b0;
`endif
    // Asynchronous reset mid-sequence flushes everything
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({state, level, rnd_valid, bus.trng_rst, err_health}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_rst", 32'({state, busy}), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
